region_shifter: RTL

//  Shifts a rectangular framebuffer region by SHIFT pixels, up to 2^SHIFT_W-1, in any of four directions.
//  It reads each source pixel through the screen-mirror read port and writes it to its destination pixel.

---
 rtl/region_shifter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/region_shifter.sv
// rtl/region_shifter.sv - framebuffer region shift engine with configurable read latency
// Copies every pixel of a bounded region from its shifted source; vacated pixels get the fill colour.
module region_shifter #(
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int COLOUR_W     = 3,
  parameter int READ_LATENCY = 2,
  parameter int SHIFT_W      = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [1:0]          dir,
  input  logic [SHIFT_W-1:0]  shift,
  input  logic [COLOUR_W-1:0] fillColour,
  input  logic [X_W-1:0]      lowerXBound,
  input  logic [X_W-1:0]      upperXBound,
  input  logic [Y_W-1:0]      lowerYBound,
  input  logic [Y_W-1:0]      upperYBound,
  input  logic [COLOUR_W-1:0] readColour,
  output logic [X_W-1:0]      readX,
  output logic [Y_W-1:0]      readY,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] writeColour,
  output logic                writeEn,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;
  localparam int CW = $clog2(READ_LATENCY) + 1;

  state_t state, nextState;

  logic [1:0]          dirR;
  logic [SHIFT_W-1:0]  shiftR;
  logic [COLOUR_W-1:0] fillR;
  logic [X_W-1:0]      loXR, hiXR;
  logic [Y_W-1:0]      loYR, hiYR;
  logic [X_W:0]        curX, candX, candSrcX, curSrcX;
  logic [Y_W:0]        curY, candY, candSrcY, curSrcY;
  logic [CW-1:0]       waitCnt;

  logic [1:0]          eDir;
  logic [SHIFT_W-1:0]  eShift;
  logic [X_W-1:0]      eLoX, eHiX;
  logic [Y_W-1:0]      eLoY, eHiY;
  logic xAtEnd, yAtEnd, lastPix, candOob, curOob, degenerate, waitDone;

  // One extra bit so that x+shift past 2^X_W-1 and x-shift below 0 both land above any upper bound.
  function automatic logic [X_W:0] srcXOf(input logic [X_W:0] p, input logic [1:0] d,
                                          input logic [SHIFT_W-1:0] s);
    logic [X_W:0] sx;
    sx = {{(X_W+1-SHIFT_W){1'b0}}, s};
    case (d)
      2'b00:   return p + sx;
      2'b01:   return p - sx;
      default: return p;
    endcase
  endfunction

  function automatic logic [Y_W:0] srcYOf(input logic [Y_W:0] p, input logic [1:0] d,
                                          input logic [SHIFT_W-1:0] s);
    logic [Y_W:0] sy;
    sy = {{(Y_W+1-SHIFT_W){1'b0}}, s};
    case (d)
      2'b10:   return p + sy;
      2'b11:   return p - sy;
      default: return p;
    endcase
  endfunction

  always_comb begin
    eDir   = (state == IDLE) ? dir         : dirR;
    eShift = (state == IDLE) ? shift       : shiftR;
    eLoX   = (state == IDLE) ? lowerXBound : loXR;
    eHiX   = (state == IDLE) ? upperXBound : hiXR;
    eLoY   = (state == IDLE) ? lowerYBound : loYR;
    eHiY   = (state == IDLE) ? upperYBound : hiYR;

    xAtEnd  = (dirR == 2'b01) ? (curX == {1'b0, loXR}) : (curX == {1'b0, hiXR});
    yAtEnd  = (dirR == 2'b11) ? (curY == {1'b0, loYR}) : (curY == {1'b0, hiYR});
    lastPix = xAtEnd && yAtEnd;

    // Candidate = the pixel handled next: the first one from IDLE, otherwise the successor of cur.
    if (state == IDLE) begin
      candX = (dir == 2'b01) ? {1'b0, upperXBound} : {1'b0, lowerXBound};
      candY = (dir == 2'b11) ? {1'b0, upperYBound} : {1'b0, lowerYBound};
    end else if (!xAtEnd) begin
      candX = (dirR == 2'b01) ? curX - 1'b1 : curX + 1'b1;
      candY = curY;
    end else begin
      candX = (dirR == 2'b01) ? {1'b0, hiXR} : {1'b0, loXR};
      candY = (dirR == 2'b11) ? curY - 1'b1 : curY + 1'b1;
    end

    candSrcX = srcXOf(candX, eDir, eShift);
    candSrcY = srcYOf(candY, eDir, eShift);
    candOob  = (candSrcX < {1'b0, eLoX}) || (candSrcX > {1'b0, eHiX}) ||
               (candSrcY < {1'b0, eLoY}) || (candSrcY > {1'b0, eHiY});
    curSrcX  = srcXOf(curX, dirR, shiftR);
    curSrcY  = srcYOf(curY, dirR, shiftR);
    curOob   = (curSrcX < {1'b0, loXR}) || (curSrcX > {1'b0, hiXR}) ||
               (curSrcY < {1'b0, loYR}) || (curSrcY > {1'b0, hiYR});

    degenerate = (shift == '0) || (lowerXBound > upperXBound) || (lowerYBound > upperYBound);
    waitDone   = (waitCnt == CW'(READ_LATENCY - 1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Fill pixels go straight to WRITE, so they cost one cycle instead of a full read.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = degenerate ? DONE : (candOob ? WRITE : ISSUE);
      ISSUE:   nextState = curOob ? WRITE : WAIT;
      WAIT:    if (waitDone) nextState = WRITE;
      WRITE:   nextState = lastPix ? DONE : (candOob ? WRITE : ISSUE);
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    writeEn = (state == WRITE);
    busy    = (state == ISSUE) || (state == WAIT) || (state == WRITE);
    done    = (state == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dirR <= '0; shiftR <= '0; fillR <= '0;
      loXR <= '0; hiXR <= '0; loYR <= '0; hiYR <= '0;
      curX <= '0; curY <= '0; waitCnt <= '0;
      readX <= '0; readY <= '0;
      x <= '0; y <= '0; writeColour <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dirR <= dir; shiftR <= shift; fillR <= fillColour;
          loXR <= lowerXBound; hiXR <= upperXBound;
          loYR <= lowerYBound; hiYR <= upperYBound;
          curX <= candX; curY <= candY;
          if (!degenerate && candOob) begin
            x <= candX[X_W-1:0]; y <= candY[Y_W-1:0]; writeColour <= fillColour;
          end
        end
        ISSUE: begin
          waitCnt <= '0;
          if (curOob) begin
            x <= curX[X_W-1:0]; y <= curY[Y_W-1:0]; writeColour <= fillR;
          end else begin
            readX <= curSrcX[X_W-1:0]; readY <= curSrcY[Y_W-1:0];
          end
        end
        WAIT: begin
          waitCnt <= waitCnt + 1'b1;
          if (waitDone) begin
            x <= curX[X_W-1:0]; y <= curY[Y_W-1:0]; writeColour <= readColour;
          end
        end
        WRITE: if (!lastPix) begin
          curX <= candX; curY <= candY;
          if (candOob) begin
            x <= candX[X_W-1:0]; y <= candY[Y_W-1:0]; writeColour <= fillR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
